// File: rtl/mips_imem_loader.sv
// mips_imem_loader
//   Packs field-level R/I/J commands into 32-bit MIPS instruction words and
//   writes them sequentially into instruction memory. This is the inverse of
//   the core's decode split. Boot and test infrastructure use it to load a
//   program while the core is held in reset.
//
// Optional feature (macro MIPS_DELAY_SLOT_NOP_EN):
//   When defined, the block writes a NOP (0x00000000) at the next address
//   after every control-transfer word.
//
// Ports:
//   clk, rst           system clock; asynchronous active-high reset
//   start, base_addr   begin a load session at base_addr (bits [1:0] dropped)
//   cmd_valid/ready    command handshake
//   cmd_fmt            0=R, 1=I, 2=J, 3=END
//   cmd_opcode .. cmd_jaddr   instruction fields
//   imem_wr_en/addr/data      write request, held until imem_wr_ack
//   imem_wr_ack        memory accepted the write this cycle
//   busy, done         session status
//   err, err_code      sticky error flag; 1=illegal encoding, 2=overflow
//   instr_count        words written this session
module mips_imem_loader #(
  parameter int unsigned PC_WIDTH  = 32,
  parameter int unsigned MAX_WORDS = 1024,
  parameter int unsigned CNT_WIDTH = $clog2(MAX_WORDS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [PC_WIDTH-1:0]  base_addr,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_fmt,
  input  logic [5:0]           cmd_opcode,
  input  logic [4:0]           cmd_rs,
  input  logic [4:0]           cmd_rt,
  input  logic [4:0]           cmd_rd,
  input  logic [4:0]           cmd_shamt,
  input  logic [5:0]           cmd_funct,
  input  logic [15:0]          cmd_imm,
  input  logic [25:0]          cmd_jaddr,
  output logic                 imem_wr_en,
  output logic [PC_WIDTH-1:0]  imem_wr_addr,
  output logic [31:0]          imem_wr_data,
  input  logic                 imem_wr_ack,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [1:0]           err_code,
  output logic [CNT_WIDTH-1:0] instr_count
);

  typedef enum logic [1:0] {
    FMT_R   = 2'd0,
    FMT_I   = 2'd1,
    FMT_J   = 2'd2,
    FMT_END = 2'd3
  } fmt_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_ILLEGAL  = 2'd1,
    ERR_OVERFLOW = 2'd2
  } err_e;

`ifdef MIPS_DELAY_SLOT_NOP_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE,
    S_NOP
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE
  } state_e;
`endif

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_WORDS);

  state_e      state, state_next;
  logic [31:0] enc_word;
  logic        cmd_legal;
  logic        hs;
  logic        full;

`ifdef MIPS_DELAY_SLOT_NOP_EN
  logic                 cmd_ct;
  logic                 ct_pend;
  logic [CNT_WIDTH-1:0] count_inc;
  assign count_inc = instr_count + CNT_WIDTH'(1);
`endif

  function automatic logic r_funct_legal(input logic [5:0] f);
    case (f)
      6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, 6'd8, 6'd9,
      6'd12, 6'd13, 6'd16, 6'd17, 6'd18, 6'd19,
      6'd24, 6'd25, 6'd26, 6'd27,
      6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38, 6'd39,
      6'd42, 6'd43:  r_funct_legal = 1'b1;
      default:       r_funct_legal = 1'b0;
    endcase
  endfunction

  function automatic logic i_opcode_legal(input logic [5:0] op);
    case (op)
      6'd1, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd11,
      6'd12, 6'd13, 6'd14, 6'd15, 6'd16, 6'd28,
      6'd32, 6'd33, 6'd35, 6'd36, 6'd37, 6'd40, 6'd41, 6'd43:
               i_opcode_legal = 1'b1;
      default: i_opcode_legal = 1'b0;
    endcase
  endfunction

  // Field packing and legality of the command currently presented.
  always_comb begin
    enc_word  = '0;
    cmd_legal = 1'b0;
`ifdef MIPS_DELAY_SLOT_NOP_EN
    cmd_ct    = 1'b0;
`endif
    case (fmt_e'(cmd_fmt))
      FMT_R: begin
        enc_word  = {cmd_opcode, cmd_rs, cmd_rt, cmd_rd, cmd_shamt, cmd_funct};
        cmd_legal = (cmd_opcode == 6'd0) && r_funct_legal(cmd_funct);
`ifdef MIPS_DELAY_SLOT_NOP_EN
        cmd_ct    = (cmd_funct == 6'd8) || (cmd_funct == 6'd9);
`endif
      end
      FMT_I: begin
        enc_word  = {cmd_opcode, cmd_rs, cmd_rt, cmd_imm};
        cmd_legal = i_opcode_legal(cmd_opcode);
`ifdef MIPS_DELAY_SLOT_NOP_EN
        cmd_ct    = (cmd_opcode >= 6'd1) && (cmd_opcode <= 6'd7);
`endif
      end
      FMT_J: begin
        enc_word  = {cmd_opcode, cmd_jaddr};
        cmd_legal = (cmd_opcode == 6'd2) || (cmd_opcode == 6'd3);
`ifdef MIPS_DELAY_SLOT_NOP_EN
        cmd_ct    = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  assign hs   = cmd_valid && cmd_ready;
  assign full = (instr_count == MAX_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Status outputs decode from the state register alone, so reset clears
  // imem_wr_en asynchronously.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    imem_wr_en = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_LOAD;
      end
      S_LOAD: begin
        cmd_ready = 1'b1;
        busy      = 1'b1;
        if (cmd_valid) begin
          if (fmt_e'(cmd_fmt) == FMT_END) state_next = S_DONE;
          else if (!cmd_legal)            state_next = S_LOAD;
          else if (full)                  state_next = S_DONE;
          else                            state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        imem_wr_en = 1'b1;
        busy       = 1'b1;
        if (imem_wr_ack) begin
`ifdef MIPS_DELAY_SLOT_NOP_EN
          if (ct_pend) state_next = (count_inc == MAX_CNT) ? S_DONE : S_NOP;
          else         state_next = S_LOAD;
`else
          state_next = S_LOAD;
`endif
        end
      end
`ifdef MIPS_DELAY_SLOT_NOP_EN
      S_NOP: begin
        imem_wr_en = 1'b1;
        busy       = 1'b1;
        if (imem_wr_ack) state_next = S_LOAD;
      end
`endif
      S_DONE: begin
        done = 1'b1;
        if (start) state_next = S_LOAD;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: write address/data, word counter and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_wr_addr <= '0;
      imem_wr_data <= '0;
      instr_count  <= '0;
      err          <= 1'b0;
      err_code     <= ERR_NONE;
`ifdef MIPS_DELAY_SLOT_NOP_EN
      ct_pend      <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            imem_wr_addr <= base_addr & ~PC_WIDTH'(3);
            instr_count  <= '0;
            err          <= 1'b0;
            err_code     <= ERR_NONE;
          end
        end
        S_LOAD: begin
          if (hs && (fmt_e'(cmd_fmt) != FMT_END)) begin
            if (!cmd_legal) begin
              if (!err) err_code <= ERR_ILLEGAL;
              err <= 1'b1;
            end else if (full) begin
              if (!err) err_code <= ERR_OVERFLOW;
              err <= 1'b1;
            end else begin
              imem_wr_data <= enc_word;
`ifdef MIPS_DELAY_SLOT_NOP_EN
              ct_pend      <= cmd_ct;
`endif
            end
          end
        end
        S_WRITE: begin
          if (imem_wr_ack) begin
            imem_wr_addr <= imem_wr_addr + PC_WIDTH'(4);
            instr_count  <= instr_count + CNT_WIDTH'(1);
`ifdef MIPS_DELAY_SLOT_NOP_EN
            // The delay-slot NOP is checked against the post-increment count.
            if (ct_pend) begin
              if (count_inc == MAX_CNT) begin
                if (!err) err_code <= ERR_OVERFLOW;
                err <= 1'b1;
              end else begin
                imem_wr_data <= '0;
              end
            end
`endif
          end
        end
`ifdef MIPS_DELAY_SLOT_NOP_EN
        S_NOP: begin
          if (imem_wr_ack) begin
            imem_wr_addr <= imem_wr_addr + PC_WIDTH'(4);
            instr_count  <= instr_count + CNT_WIDTH'(1);
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_imem_loader.sv
// tb_mips_imem_loader
//   Directed plus randomized bench for mips_imem_loader (MAX_WORDS=4).
//   Expected values come from a field/mask level model of the load session.
//   Honors MIPS_DELAY_SLOT_NOP_EN the same way as the design.
module tb_mips_imem_loader;

  localparam int unsigned PCW  = 32;
  localparam int unsigned MAXW = 4;
  localparam int unsigned CW   = $clog2(MAXW + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [31:0]   base_addr;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_fmt;
  logic [5:0]    cmd_opcode;
  logic [4:0]    cmd_rs, cmd_rt, cmd_rd, cmd_shamt;
  logic [5:0]    cmd_funct;
  logic [15:0]   cmd_imm;
  logic [25:0]   cmd_jaddr;
  logic          imem_wr_en;
  logic [31:0]   imem_wr_addr;
  logic [31:0]   imem_wr_data;
  logic          imem_wr_ack;
  logic          busy, done, err;
  logic [1:0]    err_code;
  logic [CW-1:0] instr_count;

  mips_imem_loader #(
    .PC_WIDTH (PCW),
    .MAX_WORDS(MAXW),
    .CNT_WIDTH(CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_fmt     (cmd_fmt),
    .cmd_opcode  (cmd_opcode),
    .cmd_rs      (cmd_rs),
    .cmd_rt      (cmd_rt),
    .cmd_rd      (cmd_rd),
    .cmd_shamt   (cmd_shamt),
    .cmd_funct   (cmd_funct),
    .cmd_imm     (cmd_imm),
    .cmd_jaddr   (cmd_jaddr),
    .imem_wr_en  (imem_wr_en),
    .imem_wr_addr(imem_wr_addr),
    .imem_wr_data(imem_wr_data),
    .imem_wr_ack (imem_wr_ack),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .err_code    (err_code),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Legal-value bitmaps: bit k set means value k is legal.
  logic [63:0] r_mask = 64'h00000CFF_0F0F33DD;
  logic [63:0] i_mask = 64'h00000B3B_1001FFF2;

  // Session model
  logic [31:0] m_addr;
  int unsigned m_count;
  bit          m_err;
  logic [1:0]  m_code;
  bit          m_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_legal(input int fmt, input int op, input int fn);
    case (fmt)
      0:       return (op == 0) && r_mask[fn];
      1:       return i_mask[op];
      2:       return (op == 2) || (op == 3);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_enc(input int fmt, input int op, input int rs,
                                            input int rt, input int rd, input int sh,
                                            input int fn, input int imm, input int ja);
    logic [31:0] w;
    w = 32'(op) * 32'h0400_0000;
    case (fmt)
      0: w = w + 32'(rs) * 32'h20_0000 + 32'(rt) * 32'h1_0000 + 32'(rd) * 32'h800
               + 32'(sh) * 32'd64 + 32'(fn);
      1: w = w + 32'(rs) * 32'h20_0000 + 32'(rt) * 32'h1_0000 + 32'(imm);
      default: w = w + 32'(ja);
    endcase
    return w;
  endfunction

  function automatic bit model_ct(input int fmt, input int op, input int fn);
    if (fmt == 0) return (fn == 8) || (fn == 9);
    return (op >= 1) && (op <= 7);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_overflow();
    if (!m_err) m_code = 2'd2;
    m_err  = 1'b1;
    m_done = 1'b1;
  endtask

  task automatic do_start(input logic [31:0] base);
    start     = 1'b1;
    base_addr = base;
    step();
    start   = 1'b0;
    m_addr  = base & 32'hFFFF_FFFC;
    m_count = 0;
    m_err   = 1'b0;
    m_code  = 2'd0;
    m_done  = 1'b0;
    check("start_busy",  32'(busy), 1);
    check("start_ready", 32'(cmd_ready), 1);
    check("start_done",  32'(done), 0);
    check("start_addr",  imem_wr_addr, m_addr);
    check("start_count", 32'(instr_count), m_count);
    check("start_err",   32'(err), 0);
    check("start_code",  32'(err_code), 0);
  endtask

  task automatic write_phase(input logic [31:0] exp_word, input int waits, input bit poke);
    for (int k = 0; k <= waits; k++) begin
      check("wr_en",    32'(imem_wr_en), 1);
      check("wr_addr",  imem_wr_addr, m_addr);
      check("wr_data",  imem_wr_data, exp_word);
      check("wr_ready", 32'(cmd_ready), 0);
      check("wr_busy",  32'(busy), 1);
      if (poke && k == 0) begin
        start     = 1'b1;
        base_addr = 32'h1234_5678;
      end else begin
        start = 1'b0;
      end
      imem_wr_ack = (k == waits);
      step();
      imem_wr_ack = 1'b0;
    end
    start   = 1'b0;
    m_addr  = m_addr + 32'd4;
    m_count = m_count + 1;
  endtask

  task automatic do_cmd(input int fmt, input int op, input int rs, input int rt,
                        input int rd, input int sh, input int fn, input int imm,
                        input int ja, input int waits, input bit poke);
    bit legal;
    bit ct;
    check("pre_ready", 32'(cmd_ready), 1);
    cmd_fmt    = fmt[1:0];
    cmd_opcode = op[5:0];
    cmd_rs     = rs[4:0];
    cmd_rt     = rt[4:0];
    cmd_rd     = rd[4:0];
    cmd_shamt  = sh[4:0];
    cmd_funct  = fn[5:0];
    cmd_imm    = imm[15:0];
    cmd_jaddr  = ja[25:0];
    cmd_valid  = 1'b1;
    step();
    cmd_valid = 1'b0;
    legal = model_legal(fmt, op, fn);
    ct    = model_ct(fmt, op, fn);
    if (fmt == 3) begin
      m_done = 1'b1;
    end else if (!legal) begin
      if (!m_err) m_code = 2'd1;
      m_err = 1'b1;
    end else if (m_count == MAXW) begin
      model_overflow();
    end else begin
      write_phase(model_enc(fmt, op, rs, rt, rd, sh, fn, imm, ja), waits, poke);
`ifdef MIPS_DELAY_SLOT_NOP_EN
      if (ct) begin
        if (m_count == MAXW) model_overflow();
        else                 write_phase(32'h0, 0, 1'b0);
      end
`else
      if (ct) m_done = m_done;
`endif
    end
    check("post_done",  32'(done), 32'(m_done));
    check("post_ready", 32'(cmd_ready), 32'(!m_done));
    check("post_wr_en", 32'(imem_wr_en), 0);
    check("post_addr",  imem_wr_addr, m_addr);
    check("post_count", 32'(instr_count), m_count);
    check("post_err",   32'(err), 32'(m_err));
    check("post_code",  32'(err_code), 32'(m_code));
  endtask

  task automatic rand_cmd();
    int r, fmt, op, fn;
    r  = $urandom_range(0, 11);
    fn = $urandom_range(0, 63);
    if (r == 11)     fmt = 3;
    else if (r < 4)  fmt = 0;
    else if (r < 8)  fmt = 1;
    else             fmt = 2;
    case (fmt)
      0: op = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 63) : 0;
      1: begin
        op = $urandom_range(0, 63);
        if ($urandom_range(0, 3) != 0)
          for (int t = 0; t < 64 && !i_mask[op]; t++) op = (op + 1) % 64;
      end
      2: op = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 63) : $urandom_range(2, 3);
      default: op = $urandom_range(0, 63);
    endcase
    do_cmd(fmt, op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 31), fn, $urandom_range(0, 65535),
           $urandom_range(0, 32'h3FF_FFFF), $urandom_range(0, 2), 1'b0);
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    base_addr   = '0;
    cmd_valid   = 1'b0;
    cmd_fmt     = '0;
    cmd_opcode  = '0;
    cmd_rs      = '0;
    cmd_rt      = '0;
    cmd_rd      = '0;
    cmd_shamt   = '0;
    cmd_funct   = '0;
    cmd_imm     = '0;
    cmd_jaddr   = '0;
    imem_wr_ack = 1'b0;

    // Reset values
    #2;
    check("rst_ready", 32'(cmd_ready), 0);
    check("rst_wr_en", 32'(imem_wr_en), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_done",  32'(done), 0);
    check("rst_err",   32'(err), 0);
    check("rst_addr",  imem_wr_addr, 0);
    check("rst_data",  imem_wr_data, 0);
    check("rst_code",  32'(err_code), 0);
    check("rst_count", 32'(instr_count), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    check("idle_ready", 32'(cmd_ready), 0);
    check("idle_busy",  32'(busy), 0);

    // Directed session: addi, add with held ack and ignored start, j, illegal, END
    do_start(32'h0040_0003);
    do_cmd(1, 8, 0, 8, 0, 0, 0, 5, 0, 0, 1'b0);
    do_cmd(0, 0, 8, 9, 10, 0, 32, 0, 0, 3, 1'b1);
    do_cmd(2, 2, 0, 0, 0, 0, 0, 0, 32'h010_0000, 0, 1'b0);
    do_cmd(1, 17, 1, 2, 0, 0, 0, 7, 0, 0, 1'b0);
    do_cmd(0, 0, 1, 2, 3, 0, 1, 0, 0, 0, 1'b0);
    do_cmd(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);

    // Overflow: five legal commands with room for four
    do_start(32'h0000_0100);
    for (int i = 0; i < 5; i++)
      do_cmd(1, 8, i, i + 1, 0, 0, 0, i * 3, 0, i % 2, 1'b0);
    do_start(32'h0000_0000);
    do_cmd(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);

    // Randomized sessions; the first starts near the top of the address space
    for (int s = 0; s < 8; s++) begin
      do_start((s == 0) ? 32'hFFFF_FFF7 : 32'($urandom));
      for (int n = 0; n < 10 && !m_done; n++) rand_cmd();
      if (!m_done) do_cmd(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    end

    // Reset in the middle of a write
    do_start(32'h0000_0200);
    cmd_fmt    = 2'd1;
    cmd_opcode = 6'd8;
    cmd_imm    = 16'h0042;
    cmd_valid  = 1'b1;
    step();
    cmd_valid = 1'b0;
    check("mid_wr_en", 32'(imem_wr_en), 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_wr_en", 32'(imem_wr_en), 0);
    check("arst_busy",  32'(busy), 0);
    check("arst_addr",  imem_wr_addr, 0);
    check("arst_data",  imem_wr_data, 0);
    check("arst_count", 32'(instr_count), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    check("post_rst_ready", 32'(cmd_ready), 0);
    check("post_rst_done",  32'(done), 0);
    check("post_rst_wr_en", 32'(imem_wr_en), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
